data_path: RTL and testbench
============================

Name: data_path

Overview:
- 32-bit single-bus CPU datapath containing R0–R15, HI, LO, Y, a 64-bit Z (Zhigh/Zlow), PC, IR, MAR, MDR, a C sign-extender and a 5-bit-opcode ALU.
- The external control unit drives one-hot "out" strobes onto a shared bus and "in" strobes that capture the bus on the clock edge.
- Memory is external: the block exports the MAR address, MDR data and the write strobe, and accepts read data on Mdatain.

Parameters:
- WIDTH, 32, datapath word width.
- ADDR_W, 9, memory address width, taken from MAR[8:0].

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous active-high reset
- R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Yout, InPortout, CSignOut  in  1 each  bus source selects
- R0in..R15in, HIin, LOin, Yin, PCin, IRin, MARin, MDRin  in  1 each  register load enables
- ZHighIn  in  1  load Zhigh from ALU[63:32]
- ZLowIn  in  1  load Zlow from ALU[31:0]
- Cin  in  1  load both Z halves from the ALU result
- IncPC  in  1  PC increment
- Read  in  1  MDR source select: 1 = Mdatain, 0 = bus
- Write  in  1  memory write request
- opcode  in  5  ALU operation
- Address  in  9  reserved, ignored
- Mdatain  in  32  memory read data
- InPortData  in  32  input-port value
- BusMuxOut  out  32  current bus value
- MemAddr  out  9  MAR[8:0]
- MemDataOut  out  32  MDR
- MemWrite  out  1  equals Write
- IRq  out  32  IR contents for the control unit

Behaviour:
- All registers (R0–R15, HI, LO, Y, Zhigh, Zlow, PC, IR, MAR, MDR) reset to 0 asynchronously while clear is high.
- Bus is combinational.
  - It carries the selected source.
  - No select asserted: bus = 0.
  - Multiple selects asserted: fixed priority, highest first: R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, Y, InPort, CSign.
- CSign = {13{IR[18]}, IR[18:0]}.
- Register load: on the rising clock edge with its enable high, the register captures the bus. One-cycle latency; the value is visible on the bus in the next cycle.
- MDR D-input = Read ? Mdatain : bus. MDR loads only when MDRin is high.
- PC update:
  - PCin has priority over IncPC.
  - IncPC alone: PC <= PC + 1, wrapping at 2^32.
- ALU is combinational. A = Y, B = bus, 64-bit result; unlisted results are zero-extended to 64 bits.
  - 00000/00001/00010 (ld/ldi/ldr address), 00011: A + B
  - 00100: A − B
  - 00101: A & B
  - 00110: A | B
  - 00111: logical shift right by B[4:0]
  - 01000: arithmetic shift right by B[4:0]
  - 01001: shift left by B[4:0]
  - 01010: rotate right by B[4:0]
  - 01011: rotate left by B[4:0]
  - 01111: signed A*B, full 64 bits
  - 10000: signed A/B; high = remainder, low = quotient; B = 0 gives 0
  - 10001: −B
  - 10010: ~B
  - Any other opcode: 0
  - Add/sub wrap modulo 2^32 with no flags.
- Z loading:
  - Cin or ZHighIn loads Zhigh.
  - Cin or ZLowIn loads Zlow.
  - Both Z halves capture in the same edge.
- Simultaneous "in" strobes: every enabled register captures the same bus value.
- A register may drive the bus and load in the same cycle; it captures its old value.
- clear asserted mid-sequence clears everything immediately. Memory-side outputs follow MAR/MDR, so they also read 0.

Decomposition:
- Shared package: opcode localparams, WIDTH/ADDR_W, bus-select priority encoding.
- Sub-modules:
  - register32: async clear, load enable; instantiated for every 32-bit register.
  - alu: the combinational 64-bit result.

Test Plan:
- clear pulse -> every register reads 0 on BusMuxOut when selected; MemAddr = 0; MemDataOut = 0.
- Bus = 5 with MARin for 1 cycle; bus = 0x12345678 with MDRin, Read = 0; then Write = 1 -> MemAddr = 5, MemDataOut = 0x12345678, MemWrite = 1 for exactly that cycle.
- Mdatain = 0xDEADBEEF with Read = 1 and MDRin; then MDRout + R4in; then R4out -> BusMuxOut = 0xDEADBEEF.
- Y = 7, R2 = 0xFFFFFFFD, opcode 01111, Cin; Zlowout then Zhighout -> 0xFFFFFFEB then 0xFFFFFFFF.
- Y = 0x80000001, bus = 4, opcode 01010, ZLowIn -> Zlow = 0x18000000. Same operands with opcode 01000 -> Zlow = 0xF8000000.
- PC = 0xFFFFFFFF, IncPC -> PC = 0. IR = 0x0007FFFF, CSignOut -> bus 0xFFFFFFFF. Y = 9, bus = 0, opcode 10000 -> Z = 0.

Source files
------------

// File: rtl/data_path_pkg.sv
// rtl/data_path_pkg.sv - shared widths, ALU opcodes and bus source priority indices
package data_path_pkg;

   localparam int WIDTH  = 32;
   localparam int ADDR_W = 9;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_LDR  = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   // Bus source indices; a lower index wins when several selects are high.
   localparam int NUM_SRC   = 25;
   localparam int SRC_HI    = 16;
   localparam int SRC_LO    = 17;
   localparam int SRC_ZHI   = 18;
   localparam int SRC_ZLO   = 19;
   localparam int SRC_PC    = 20;
   localparam int SRC_MDR   = 21;
   localparam int SRC_Y     = 22;
   localparam int SRC_INP   = 23;
   localparam int SRC_CSIGN = 24;

   function automatic logic [WIDTH-1:0] csign(input logic [WIDTH-1:0] ir);
      return {{13{ir[18]}}, ir[18:0]};
   endfunction

endpackage

// File: rtl/data_path_alu.sv
// rtl/data_path_alu.sv - combinational ALU, A from Y and B from the bus, 64-bit result
module data_path_alu
   import data_path_pkg::*;
(
   input  logic [4:0]         op_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] res_o
);

   logic [4:0]                sh;
   logic [5:0]                rsh;
   logic signed [2*WIDTH-1:0] a_ext, b_ext;
   logic signed [WIDTH-1:0]   quot, rem;

   assign sh    = b_i[4:0];
   assign rsh   = 6'd32 - {1'b0, sh};
   assign a_ext = {{WIDTH{a_i[WIDTH-1]}}, a_i};
   assign b_ext = {{WIDTH{b_i[WIDTH-1]}}, b_i};

   // Divide by zero is defined as zero rather than left to simulator X.
   always_comb begin
      quot = '0;
      rem  = '0;
      if (b_i != '0) begin
         quot = $signed(a_i) / $signed(b_i);
         rem  = $signed(a_i) % $signed(b_i);
      end
   end

   always_comb begin
      res_o = '0;
      unique case (op_i)
         OP_LD, OP_LDI, OP_LDR, OP_ADD: res_o = {{WIDTH{1'b0}}, a_i + b_i};
         OP_SUB:  res_o = {{WIDTH{1'b0}}, a_i - b_i};
         OP_AND:  res_o = {{WIDTH{1'b0}}, a_i & b_i};
         OP_OR:   res_o = {{WIDTH{1'b0}}, a_i | b_i};
         OP_SHR:  res_o = {{WIDTH{1'b0}}, a_i >> sh};
         OP_SHRA: res_o = {{WIDTH{1'b0}}, $unsigned($signed(a_i) >>> sh)};
         OP_SHL:  res_o = {{WIDTH{1'b0}}, a_i << sh};
         OP_ROR:  res_o = {{WIDTH{1'b0}}, (a_i >> sh) | (a_i << rsh)};
         OP_ROL:  res_o = {{WIDTH{1'b0}}, (a_i << sh) | (a_i >> rsh)};
         OP_MUL:  res_o = a_ext * b_ext;
         OP_DIV:  res_o = {rem, quot};
         OP_NEG:  res_o = {{WIDTH{1'b0}}, {WIDTH{1'b0}} - b_i};
         OP_NOT:  res_o = {{WIDTH{1'b0}}, ~b_i};
         default: res_o = '0;
      endcase
   end

endmodule

// File: rtl/data_path_register32.sv
// rtl/data_path_register32.sv - word register with async clear and load enable
module data_path_register32
   import data_path_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ld_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     q_q <= '0;
      else if (ld_i) q_q <= d_i;
   end

   assign q_o = q_q;

endmodule

// File: rtl/data_path.sv
// rtl/data_path.sv - single-bus CPU datapath: register file, special registers, bus mux, ALU
module data_path
   import data_path_pkg::*;
(
   input  logic              clock,
   input  logic              clear,
   input  logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
   input  logic R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
   input  logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Yout, InPortout, CSignOut,
   input  logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
   input  logic R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
   input  logic HIin, LOin, Yin, PCin, IRin, MARin, MDRin,
   input  logic              ZHighIn,
   input  logic              ZLowIn,
   input  logic              Cin,
   input  logic              IncPC,
   input  logic              Read,
   input  logic              Write,
   input  logic [4:0]        opcode,
   input  logic [ADDR_W-1:0] Address,
   input  logic [WIDTH-1:0]  Mdatain,
   input  logic [WIDTH-1:0]  InPortData,
   output logic [WIDTH-1:0]  BusMuxOut,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [WIDTH-1:0]  MemDataOut,
   output logic              MemWrite,
   output logic [WIDTH-1:0]  IRq
);

   logic [WIDTH-1:0]   bus;
   logic [WIDTH-1:0]   r_q [16];
   logic [WIDTH-1:0]   hi_q, lo_q, y_q, zhi_q, zlo_q, pc_q, ir_q, mar_q, mdr_q;
   logic [WIDTH-1:0]   pc_d, mdr_d;
   logic [2*WIDTH-1:0] alu_res;
   logic [15:0]        r_in;
   logic [NUM_SRC-1:0] sel;
   logic [WIDTH-1:0]   src [NUM_SRC];
   logic               addr_unused;

   assign r_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
   assign sel  = {CSignOut, InPortout, Yout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout,
                  R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

   for (genvar g = 0; g < 16; g++) begin : g_gpr
      data_path_register32 u_r (.clk_i(clock), .rst_i(clear), .ld_i(r_in[g]), .d_i(bus), .q_o(r_q[g]));
   end

   assign pc_d  = PCin ? bus : pc_q + 32'd1;
   assign mdr_d = Read ? Mdatain : bus;

   data_path_register32 u_hi  (.clk_i(clock), .rst_i(clear), .ld_i(HIin),          .d_i(bus),                    .q_o(hi_q));
   data_path_register32 u_lo  (.clk_i(clock), .rst_i(clear), .ld_i(LOin),          .d_i(bus),                    .q_o(lo_q));
   data_path_register32 u_y   (.clk_i(clock), .rst_i(clear), .ld_i(Yin),           .d_i(bus),                    .q_o(y_q));
   data_path_register32 u_zhi (.clk_i(clock), .rst_i(clear), .ld_i(Cin | ZHighIn), .d_i(alu_res[2*WIDTH-1:WIDTH]), .q_o(zhi_q));
   data_path_register32 u_zlo (.clk_i(clock), .rst_i(clear), .ld_i(Cin | ZLowIn),  .d_i(alu_res[WIDTH-1:0]),     .q_o(zlo_q));
   data_path_register32 u_pc  (.clk_i(clock), .rst_i(clear), .ld_i(PCin | IncPC),  .d_i(pc_d),                   .q_o(pc_q));
   data_path_register32 u_ir  (.clk_i(clock), .rst_i(clear), .ld_i(IRin),          .d_i(bus),                    .q_o(ir_q));
   data_path_register32 u_mar (.clk_i(clock), .rst_i(clear), .ld_i(MARin),         .d_i(bus),                    .q_o(mar_q));
   data_path_register32 u_mdr (.clk_i(clock), .rst_i(clear), .ld_i(MDRin),         .d_i(mdr_d),                  .q_o(mdr_q));

   data_path_alu u_alu (.op_i(opcode), .a_i(y_q), .b_i(bus), .res_o(alu_res));

   always_comb begin
      for (int i = 0; i < 16; i++) src[i] = r_q[i];
      src[SRC_HI]    = hi_q;
      src[SRC_LO]    = lo_q;
      src[SRC_ZHI]   = zhi_q;
      src[SRC_ZLO]   = zlo_q;
      src[SRC_PC]    = pc_q;
      src[SRC_MDR]   = mdr_q;
      src[SRC_Y]     = y_q;
      src[SRC_INP]   = InPortData;
      src[SRC_CSIGN] = csign(ir_q);
   end

   // Scan from lowest priority upward so the highest-priority select is written last.
   always_comb begin
      bus = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (sel[i]) bus = src[i];
      end
   end

   assign BusMuxOut   = bus;
   assign MemAddr     = mar_q[ADDR_W-1:0];
   assign MemDataOut  = mdr_q;
   assign MemWrite    = Write;
   assign IRq         = ir_q;
   assign addr_unused = ^{Address, mar_q[WIDTH-1:ADDR_W]};

endmodule

// File: tb/tb_data_path.sv
// tb/tb_data_path.sv - directed self-checking bench for data_path
module tb_data_path;

   logic        clock, clear;
   logic [24:0] outs;
   logic [22:0] ins;
   logic        ZHighIn, ZLowIn, Cin, IncPC, Read, Write;
   logic [4:0]  opcode;
   logic [8:0]  Address;
   logic [31:0] Mdatain, InPortData;
   logic [31:0] BusMuxOut, MemDataOut, IRq;
   logic [8:0]  MemAddr;
   logic        MemWrite;
   int          checks = 0;
   int          failures = 0;

   data_path dut (
      .clock(clock), .clear(clear),
      .R0out(outs[0]), .R1out(outs[1]), .R2out(outs[2]), .R3out(outs[3]),
      .R4out(outs[4]), .R5out(outs[5]), .R6out(outs[6]), .R7out(outs[7]),
      .R8out(outs[8]), .R9out(outs[9]), .R10out(outs[10]), .R11out(outs[11]),
      .R12out(outs[12]), .R13out(outs[13]), .R14out(outs[14]), .R15out(outs[15]),
      .HIout(outs[16]), .LOout(outs[17]), .Zhighout(outs[18]), .Zlowout(outs[19]),
      .PCout(outs[20]), .MDRout(outs[21]), .Yout(outs[22]), .InPortout(outs[23]),
      .CSignOut(outs[24]),
      .R0in(ins[0]), .R1in(ins[1]), .R2in(ins[2]), .R3in(ins[3]),
      .R4in(ins[4]), .R5in(ins[5]), .R6in(ins[6]), .R7in(ins[7]),
      .R8in(ins[8]), .R9in(ins[9]), .R10in(ins[10]), .R11in(ins[11]),
      .R12in(ins[12]), .R13in(ins[13]), .R14in(ins[14]), .R15in(ins[15]),
      .HIin(ins[16]), .LOin(ins[17]), .Yin(ins[18]), .PCin(ins[19]),
      .IRin(ins[20]), .MARin(ins[21]), .MDRin(ins[22]),
      .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Cin(Cin), .IncPC(IncPC),
      .Read(Read), .Write(Write), .opcode(opcode), .Address(Address),
      .Mdatain(Mdatain), .InPortData(InPortData),
      .BusMuxOut(BusMuxOut), .MemAddr(MemAddr), .MemDataOut(MemDataOut),
      .MemWrite(MemWrite), .IRq(IRq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive v from the input port into every register in mask for one edge.
   task automatic put(input logic [31:0] v, input logic [22:0] mask);
      InPortData = v;
      outs = 25'd1 << 23;
      ins  = mask;
      @(negedge clock);
      outs = '0;
      ins  = '0;
   endtask

   task automatic show(input int s);
      outs = 25'd1 << s;
      #1;
   endtask

   // One ALU edge with B taken from the input port.
   task automatic alu_op(input logic [4:0] op, input logic [31:0] b, input logic c, input logic zl);
      InPortData = b;
      outs   = 25'd1 << 23;
      opcode = op;
      Cin    = c;
      ZLowIn = zl;
      @(negedge clock);
      outs   = '0;
      Cin    = 1'b0;
      ZLowIn = 1'b0;
   endtask

   initial begin
      clear = 1'b1; outs = '0; ins = '0;
      ZHighIn = 0; ZLowIn = 0; Cin = 0; IncPC = 0; Read = 0; Write = 0;
      opcode = '0; Address = '0; Mdatain = '0; InPortData = '0;
      repeat (2) @(negedge clock);
      #1;
      check("rst_memaddr", {23'b0, MemAddr}, 32'h0);
      check("rst_memdata", MemDataOut, 32'h0);
      check("rst_bus_idle", BusMuxOut, 32'h0);
      check("rst_memwrite", {31'b0, MemWrite}, 32'h0);
      clear = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (i != 23) begin
            show(i);
            check($sformatf("rst_src%0d", i), BusMuxOut, 32'h0);
         end
      end
      outs = '0;
      @(negedge clock);

      put(32'd5, 23'd1 << 21);
      put(32'h12345678, 23'd1 << 22);
      Write = 1'b1;
      #1;
      check("wr_memaddr", {23'b0, MemAddr}, 32'd5);
      check("wr_memdata", MemDataOut, 32'h12345678);
      check("wr_memwrite_hi", {31'b0, MemWrite}, 32'd1);
      @(negedge clock);
      Write = 1'b0;
      #1;
      check("wr_memwrite_lo", {31'b0, MemWrite}, 32'd0);

      Mdatain = 32'hDEADBEEF; Read = 1'b1; ins = 23'd1 << 22;
      @(negedge clock);
      Read = 1'b0; ins = 23'd1 << 4; outs = 25'd1 << 21;
      @(negedge clock);
      ins = '0;
      show(4);
      check("rd_r4", BusMuxOut, 32'hDEADBEEF);
      check("rd_memdata", MemDataOut, 32'hDEADBEEF);

      put(32'd7, 23'd1 << 18);
      put(32'hFFFFFFFD, 23'd1 << 2);
      outs = 25'd1 << 2; opcode = 5'b01111; Cin = 1'b1;
      @(negedge clock);
      Cin = 1'b0;
      show(19); check("mul_zlo", BusMuxOut, 32'hFFFFFFEB);
      show(18); check("mul_zhi", BusMuxOut, 32'hFFFFFFFF);

      put(32'h80000001, 23'd1 << 18);
      alu_op(5'b01010, 32'd4, 1'b0, 1'b1);
      show(19); check("ror_zlo", BusMuxOut, 32'h18000000);
      show(18); check("ror_zhi_kept", BusMuxOut, 32'hFFFFFFFF);
      alu_op(5'b01000, 32'd4, 1'b0, 1'b1);
      show(19); check("asr_zlo", BusMuxOut, 32'hF8000000);

      put(32'hFFFFFFFF, 23'd1 << 19);
      IncPC = 1'b1;
      @(negedge clock);
      IncPC = 1'b0;
      show(20); check("pc_wrap", BusMuxOut, 32'h0);
      InPortData = 32'h100; outs = 25'd1 << 23; ins = 23'd1 << 19; IncPC = 1'b1;
      @(negedge clock);
      IncPC = 1'b0; ins = '0;
      show(20); check("pc_in_prio", BusMuxOut, 32'h100);

      put(32'h0007FFFF, 23'd1 << 20);
      show(24); check("csign_neg", BusMuxOut, 32'hFFFFFFFF);
      check("irq", IRq, 32'h0007FFFF);
      put(32'h0003FFFF, 23'd1 << 20);
      show(24); check("csign_pos", BusMuxOut, 32'h0003FFFF);

      put(32'd9, 23'd1 << 18);
      alu_op(5'b00100, 32'd10, 1'b1, 1'b0);
      show(19); check("sub_zlo", BusMuxOut, 32'hFFFFFFFF);
      show(18); check("sub_zhi", BusMuxOut, 32'h0);
      put(32'hFFFFFFF9, 23'd1 << 18);
      alu_op(5'b10000, 32'd2, 1'b1, 1'b0);
      show(19); check("div_quot", BusMuxOut, 32'hFFFFFFFD);
      show(18); check("div_rem", BusMuxOut, 32'hFFFFFFFF);
      put(32'd9, 23'd1 << 18);
      alu_op(5'b10000, 32'd0, 1'b1, 1'b0);
      show(19); check("div0_zlo", BusMuxOut, 32'h0);
      show(18); check("div0_zhi", BusMuxOut, 32'h0);

      outs = (25'd1 << 4) | (25'd1 << 22);
      #1;
      check("prio_r4_over_y", BusMuxOut, 32'hDEADBEEF);
      outs = (25'd1 << 23) | (25'd1 << 24); InPortData = 32'h0BADF00D;
      #1;
      check("prio_inp_over_csign", BusMuxOut, 32'h0BADF00D);

      put(32'h11111111, 23'd1 << 5);
      outs = 25'd1 << 5; ins = (23'd1 << 5) | (23'd1 << 6);
      @(negedge clock);
      ins = '0;
      show(6); check("selfload_r6", BusMuxOut, 32'h11111111);
      show(5); check("selfload_r5", BusMuxOut, 32'h11111111);
      put(32'hA5A5A5A5, (23'd1 << 7) | (23'd1 << 16));
      show(7);  check("multi_r7", BusMuxOut, 32'hA5A5A5A5);
      show(16); check("multi_hi", BusMuxOut, 32'hA5A5A5A5);

      show(4);
      #2;
      clear = 1'b1;
      #1;
      check("clr_r4", BusMuxOut, 32'h0);
      check("clr_memdata", MemDataOut, 32'h0);
      check("clr_memaddr", {23'b0, MemAddr}, 32'h0);
      clear = 1'b0;
      outs = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
